// File: rtl/wb_host_pkg.sv
// wb_host_pkg: shared FSM encoding and constants for the Wishbone host initiator
package wb_host_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;
  localparam int WB_SEL_W = 4;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/wb_host_initiator.sv
// wb_host_initiator: single-transfer Wishbone classic master driven by a valid/ready command channel
// Define WB_HOST_TIMEOUT_EN to abort transfers whose ack never arrives within TIMEOUT_CYCLES.
module wb_host_initiator
  import wb_host_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  input  logic [AW-1:0]       cmd_adr_i,
  input  logic [DW-1:0]       cmd_dat_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DW-1:0]       rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [AW-1:0]       wbm_adr_o,
  output logic [DW-1:0]       wbm_dat_o,
  input  logic [DW-1:0]       wbm_dat_i,
  input  logic                wbm_ack_i,
  output logic                busy_o
);
  state_t state;
`ifdef WB_HOST_TIMEOUT_EN
  logic [15:0] cnt;
  logic tmo;
  assign tmo = cnt == 16'(TIMEOUT_CYCLES - 1);
`else
  assign rsp_err_o = 1'b0;
`endif
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      busy_o      <= 1'b0;
`ifdef WB_HOST_TIMEOUT_EN
      rsp_err_o   <= 1'b0;
      cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE:
          if (cmd_valid_i && cmd_ready_o) begin
            wbm_we_o    <= cmd_we_i;
            wbm_sel_o   <= cmd_sel_i;
            wbm_adr_o   <= cmd_adr_i;
            wbm_dat_o   <= cmd_dat_i;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= BUS;
`ifdef WB_HOST_TIMEOUT_EN
            cnt         <= '0;
`endif
          end else begin
            cmd_ready_o <= 1'b1;
          end
        BUS:
          if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
`ifdef WB_HOST_TIMEOUT_EN
            rsp_err_o   <= 1'b0;
`endif
          end
`ifdef WB_HOST_TIMEOUT_EN
          else if (tmo) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
`endif
        RESP:
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/wb_host_initiator.md
Name: wb_host_initiator

Overview:
- Wishbone classic single-transfer initiator (bus master) for the user area; the counterpart of the wrapper's slave port.
- Accepts read/write commands on a valid/ready command channel, drives one Wishbone cycle per command, and returns the read data or status on a valid/ready response channel.
- Lets on-chip controllers, or LA-driven test logic, exercise user-area Wishbone slaves such as the example project without the management SoC.

Parameters:
- AW, 32, address width
- DW, 32, data width (must be 32; sel width fixed at 4)
- TIMEOUT_CYCLES, 255, maximum cycles stb may wait for ack (used only with the optional feature), range 1..65535

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_we_i  in  1  1=write, 0=read
- cmd_sel_i  in  4  byte selects
- cmd_adr_i  in  AW  byte address
- cmd_dat_i  in  DW  write data
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_dat_o  out  DW  read data (0 for writes and errors)
- rsp_err_o  out  1  transfer aborted by timeout
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  4  Wishbone byte selects
- wbm_adr_o  out  AW  Wishbone address
- wbm_dat_o  out  DW  Wishbone write data
- wbm_dat_i  in  DW  Wishbone read data
- wbm_ack_i  in  1  Wishbone acknowledge
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset is asynchronous and active-high. While wb_rst_i is asserted, all outputs are 0, the FSM is in IDLE, and the counters are cleared.
- A reset during BUS drops cyc/stb immediately; the in-flight command is discarded and no response is produced.
- All outputs are registered. There is one clock domain, wb_clk_i.
- FSM has three states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i&cmd_ready_o, register we/sel/adr/dat onto the wbm_* outputs, assert cyc=stb=1, go to BUS.
  - Latency: the command is accepted at edge N and cyc/stb are high from edge N onward.
- BUS:
  - cmd_ready_o=0; cyc, stb and all wbm_* outputs are held stable.
  - On the first edge where wbm_ack_i=1: deassert cyc/stb at that edge, capture wbm_dat_i into rsp_dat_o if read (0 if write), set rsp_err_o=0, rsp_valid_o=1, go to RESP.
  - Minimum command-to-response latency: 2 edges with a zero-wait slave.
- RESP:
  - rsp_valid_o, rsp_dat_o and rsp_err_o are held until rsp_ready_i=1.
  - On that edge: clear rsp_valid_o, go to IDLE; cmd_ready_o is 1 from that edge.
  - No command/response overlap: at most one outstanding transaction.
- wbm_ack_i outside BUS is ignored; no state change, no response.
- After completion, wbm_we_o/sel_o/adr_o/dat_o keep their last values; only cyc/stb are required to be 0.
- cmd_* inputs are ignored except in IDLE.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: WB_HOST_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on entry to BUS and increments each BUS cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES with no ack, deassert cyc/stb, set rsp_err_o=1 and rsp_dat_o=0, go to RESP.
  - An ack on the same edge as the timeout wins: normal completion, err=0.
- Undefined:
  - No counter; BUS waits indefinitely for ack.
  - rsp_err_o is tied to 0.

Decomposition:
- Shared package wb_host_pkg:
  - FSM state encoding (IDLE=2'd0, BUS=2'd1, RESP=2'd2)
  - WB_SEL_W=4
  - default TIMEOUT_CYCLES
- No sub-module required. The timeout counter is inline, guarded by the macro.

Test Plan:
- Write, zero-wait slave: cmd we=1 adr=0x3000_0004 dat=0xA5A5_1234 sel=4'hF → cyc/stb high for 1 cycle with matching wbm_* outputs; rsp_valid with rsp_dat=0, err=0; cmd_ready low from accept until rsp handshake.
- Read with 3 wait states: slave acks on the 4th cycle with dat=0xCAFE_F00D → rsp_dat=0xCAFE_F00D; cyc/stb high exactly 4 cycles.
- Response backpressure: rsp_ready low for 5 cycles → rsp_valid/dat stable; a second cmd_valid is not accepted until the cycle after the rsp handshake.
- Spurious ack in IDLE and in RESP → no state change, no extra response.
- Timeout (macro on, TIMEOUT_CYCLES=8, slave never acks) → cyc drops after 8 wait cycles; rsp_err=1, rsp_dat=0. Repeat with ack on the timeout edge → err=0, data captured.
- Reset asserted mid-BUS → cyc/stb/rsp_valid go 0 asynchronously; after release, a fresh read completes normally.
